// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues fetch requests, buffers returned
// words in a 2-entry FIFO and handles redirects with in-flight discard.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic [31:0] pc_next,
    output logic        mem_req,
    output logic [31:0] mem_pc,
    input  logic        mem_ack,
    input  logic [31:0] mem_inst
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] old_pc_q, old_pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc0_q, pc0_d, inst0_q, inst0_d;
    logic [31:0] pc1_q, pc1_d, inst1_q, inst1_d;

    logic        pop;
    logic        push;
    logic [1:0]  cnt_pop;
    logic [1:0]  cnt_push;

    assign pop      = (cnt_q != 2'd0) && !stall;
    assign cnt_pop  = cnt_q - {1'b0, pop};
    assign push     = (state_q == S_REQ) && mem_ack && !redirect;
    assign cnt_push = cnt_pop + 2'd1;

    // State, PC and FIFO registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            old_pc_q   <= 32'h0;
            cnt_q      <= 2'd0;
            pc0_q      <= 32'h0;
            inst0_q    <= 32'h0;
            pc1_q      <= 32'h0;
            inst1_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            old_pc_q   <= old_pc_d;
            cnt_q      <= cnt_d;
            pc0_q      <= pc0_d;
            inst0_q    <= inst0_d;
            pc1_q      <= pc1_d;
            inst1_q    <= inst1_d;
        end
    end

    // Next-state: redirect wins; a request stays up until acknowledged
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (redirect || (cnt_pop < 2'd2)) state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    state_d = mem_ack ? S_REQ : S_DISCARD;
                end else if (mem_ack) begin
                    state_d = (cnt_push < 2'd2) ? S_REQ : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (!redirect && mem_ack) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO push/pop and fetch address update; redirect flushes the FIFO
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        old_pc_d   = old_pc_q;
        cnt_d      = cnt_q;
        pc0_d      = pc0_q;
        inst0_d    = inst0_q;
        pc1_d      = pc1_q;
        inst1_d    = inst1_q;
        if (redirect) begin
            cnt_d      = 2'd0;
            fetch_pc_d = redirect_pc;
            if ((state_q == S_REQ) && !mem_ack) old_pc_d = fetch_pc_q;
        end else begin
            cnt_d = cnt_pop + {1'b0, push};
            if (pop) begin
                pc0_d   = pc1_q;
                inst0_d = inst1_q;
            end
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                if (cnt_pop == 2'd0) begin
                    pc0_d   = fetch_pc_q;
                    inst0_d = mem_inst;
                end else begin
                    pc1_d   = fetch_pc_q;
                    inst1_d = mem_inst;
                end
            end
        end
    end

    // Outputs come straight from registered state and the FIFO head
    always_comb begin
        inst_valid = (cnt_q != 2'd0);
        inst       = inst0_q;
        pc_out     = pc0_q;
        pc_next    = pc0_q + 32'd4;
        mem_req    = (state_q != S_IDLE);
        mem_pc     = (state_q == S_DISCARD) ? old_pc_q : fetch_pc_q;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// run checked against a program-order reference.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic [31:0] pc_next;
    logic        mem_req;
    logic [31:0] mem_pc;
    logic        mem_ack;
    logic [31:0] mem_inst;

    int n_chk = 0;
    int n_pass = 0;

    // Memory model: ack after 'lat' extra wait cycles, gated by mem_en
    logic        mem_en = 1'b1;
    int          lat = 0;
    int          wcnt = 0;

    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_ack  = mem_en && mem_req && (wcnt >= lat);
    assign mem_inst = mem_ack ? f(mem_pc) : 32'h0;

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc_out     (pc_out),
        .pc_next    (pc_next),
        .mem_req    (mem_req),
        .mem_pc     (mem_pc),
        .mem_ack    (mem_ack),
        .mem_inst   (mem_inst)
    );

    // Leaves the bench at a negedge with rst just released
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL reset_ctl valid=%b req=%b exp 0 0", inst_valid, mem_req);
        else n_pass++;
        n_chk++;
        if (inst !== 32'h0 || pc_out !== 32'h0 || pc_next !== 32'h4)
            $display("FAIL reset_data inst=%h pc=%h nx=%h exp 0 0 4", inst, pc_out, pc_next);
        else n_pass++;
    endtask

    task automatic test_zero_wait();
        lat = 0;
        mem_en = 1'b1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_chk++;
            if (mem_req !== 1'b1 || mem_pc !== 32'(4 * k))
                $display("FAIL zw_mem k=%0d req=%b pc=%h exp 1 %h", k, mem_req, mem_pc, 32'(4 * k));
            else n_pass++;
            n_chk++;
            if (k == 0) begin
                if (inst_valid !== 1'b0)
                    $display("FAIL zw_first valid=%b exp 0", inst_valid);
                else n_pass++;
            end else begin
                if (inst_valid !== 1'b1 || pc_out !== 32'(4 * (k - 1)) ||
                    inst !== f(32'(4 * (k - 1))) || pc_next !== 32'(4 * k))
                    $display("FAIL zw_out k=%0d v=%b pc=%h inst=%h exp pc %h", k,
                             inst_valid, pc_out, inst, 32'(4 * (k - 1)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_latency3();
        lat = 2;
        mem_en = 1'b1;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_chk++;
            if (mem_pc !== 32'(4 * (k / 3)) || mem_req !== 1'b1)
                $display("FAIL lat3_mem k=%0d pc=%h exp %h", k, mem_pc, 32'(4 * (k / 3)));
            else n_pass++;
            n_chk++;
            if (inst_valid !== (k >= 3 && k % 3 == 0))
                $display("FAIL lat3_valid k=%0d valid=%b exp %b", k, inst_valid,
                         (k >= 3 && k % 3 == 0));
            else n_pass++;
            if (k >= 3 && k % 3 == 0) begin
                n_chk++;
                if (pc_out !== 32'(4 * (k / 3 - 1)))
                    $display("FAIL lat3_pc k=%0d pc=%h exp %h", k, pc_out, 32'(4 * (k / 3 - 1)));
                else n_pass++;
            end
        end
        lat = 0;
    endtask

    task automatic test_stall();
        lat = 0;
        mem_en = 1'b1;
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3 || (k >= 4 && k <= 8)) begin
                n_chk++;
                if (pc_out !== 32'h8 || inst_valid !== 1'b1)
                    $display("FAIL stall_head k=%0d pc=%h exp 8", k, pc_out);
                else n_pass++;
            end
            if (k >= 4 && k <= 8) begin
                n_chk++;
                if (mem_req !== 1'b0)
                    $display("FAIL stall_req k=%0d req=%b exp 0", k, mem_req);
                else n_pass++;
            end
            if (k == 9) begin
                n_chk++;
                if (pc_out !== 32'hC || mem_req !== 1'b1 || mem_pc !== 32'h10)
                    $display("FAIL stall_resume pc=%h req=%b mpc=%h exp C 1 10",
                             pc_out, mem_req, mem_pc);
                else n_pass++;
            end
            if (k == 10) begin
                n_chk++;
                if (pc_out !== 32'h10 || inst_valid !== 1'b1)
                    $display("FAIL stall_next pc=%h exp 10", pc_out);
                else n_pass++;
            end
            stall = (k >= 3 && k <= 7);
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect_discard();
        lat = 0;
        mem_en = 1'b1;
        do_reset();
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k >= 9 && inst_valid === 1'b1 && pc_out === 32'h20) begin
                n_chk++;
                $display("FAIL disc_leak k=%0d pc=%h must not be 20", k, pc_out);
            end
            if (k >= 9 && k <= 11) begin
                n_chk++;
                if (mem_req !== 1'b1 || mem_pc !== 32'h20 || inst_valid !== 1'b0)
                    $display("FAIL disc_hold k=%0d req=%b pc=%h v=%b exp 1 20 0",
                             k, mem_req, mem_pc, inst_valid);
                else n_pass++;
            end
            if (k == 12) begin
                n_chk++;
                if (mem_pc !== 32'h100 || mem_req !== 1'b1 || inst_valid !== 1'b0)
                    $display("FAIL disc_next pc=%h v=%b exp 100 0", mem_pc, inst_valid);
                else n_pass++;
            end
            if (k == 13) begin
                n_chk++;
                if (pc_out !== 32'h100 || inst_valid !== 1'b1 || inst !== f(32'h100))
                    $display("FAIL disc_out pc=%h v=%b exp 100 1", pc_out, inst_valid);
                else n_pass++;
            end
            redirect = (k == 8);
            redirect_pc = 32'h100;
            if (k == 8) mem_en = 1'b0;
            if (k == 11) mem_en = 1'b1;
        end
        redirect = 1'b0;
        mem_en = 1'b1;
    endtask

    task automatic test_redirect_ack();
        lat = 0;
        mem_en = 1'b1;
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                n_chk++;
                if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_pc !== 32'h200)
                    $display("FAIL rack_flush v=%b req=%b pc=%h exp 0 1 200",
                             inst_valid, mem_req, mem_pc);
                else n_pass++;
            end
            if (k == 6) begin
                n_chk++;
                if (inst_valid !== 1'b1 || pc_out !== 32'h200)
                    $display("FAIL rack_out v=%b pc=%h exp 1 200", inst_valid, pc_out);
                else n_pass++;
            end
            redirect = (k == 4);
            stall = (k == 4);
            redirect_pc = 32'h200;
        end
        redirect = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_second_redirect();
        lat = 0;
        mem_en = 1'b1;
        do_reset();
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) begin
                n_chk++;
                if (mem_pc !== 32'hC || mem_req !== 1'b1)
                    $display("FAIL red2_hold pc=%h exp C", mem_pc);
                else n_pass++;
            end
            if (k == 6) begin
                n_chk++;
                if (mem_pc !== 32'h300 || mem_req !== 1'b1)
                    $display("FAIL red2_fetch pc=%h exp 300", mem_pc);
                else n_pass++;
            end
            if (k == 7) begin
                n_chk++;
                if (pc_out !== 32'h300 || inst_valid !== 1'b1)
                    $display("FAIL red2_out pc=%h v=%b exp 300 1", pc_out, inst_valid);
                else n_pass++;
            end
            redirect = (k == 3 || k == 4);
            redirect_pc = (k == 3) ? 32'h100 : 32'h300;
            if (k == 3) mem_en = 1'b0;
            if (k == 5) mem_en = 1'b1;
        end
        redirect = 1'b0;
        mem_en = 1'b1;
    endtask

    task automatic test_wrap();
        lat = 0;
        mem_en = 1'b1;
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) begin
                n_chk++;
                if (mem_pc !== 32'hFFFF_FFFC)
                    $display("FAIL wrap_req pc=%h exp FFFFFFFC", mem_pc);
                else n_pass++;
            end
            if (k == 4) begin
                n_chk++;
                if (mem_pc !== 32'h0 || pc_out !== 32'hFFFF_FFFC || pc_next !== 32'h0)
                    $display("FAIL wrap_next mpc=%h pc=%h nx=%h exp 0 FFFFFFFC 0",
                             mem_pc, pc_out, pc_next);
                else n_pass++;
            end
            if (k == 5) begin
                n_chk++;
                if (pc_out !== 32'h0 || inst_valid !== 1'b1)
                    $display("FAIL wrap_out pc=%h exp 0", pc_out);
                else n_pass++;
            end
            redirect = (k == 2);
            redirect_pc = 32'hFFFF_FFFC;
        end
        redirect = 1'b0;
    endtask

    task automatic test_reset_mid_request();
        lat = 0;
        mem_en = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (mem_req !== 1'b1 || mem_pc !== 32'h0)
            $display("FAIL mid_pending req=%b pc=%h exp 1 0", mem_req, mem_pc);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL mid_abandon req=%b v=%b exp 0 0", mem_req, inst_valid);
        else n_pass++;
        rst = 1'b0;
        mem_en = 1'b1;
        @(negedge clk);
        n_chk++;
        if (mem_req !== 1'b1 || mem_pc !== 32'h0)
            $display("FAIL mid_restart req=%b pc=%h exp 1 0", mem_req, mem_pc);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] pend_pc;
        logic        pend;
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        int          ndel;
        exp_pc = 32'h0;
        pend = 1'b0;
        pend_pc = 32'h0;
        ndel = 0;
        mem_en = 1'b1;
        lat = 0;
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            lat = $urandom_range(0, 3);
            #1;
            if (pend) begin
                n_chk++;
                if (mem_req !== 1'b1 || mem_pc !== pend_pc)
                    $display("FAIL rnd_stable k=%0d req=%b pc=%h exp %h", k, mem_req, mem_pc, pend_pc);
                else n_pass++;
            end
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FFC);
            if (rd) begin
                exp_pc = rpc;
            end else if (inst_valid === 1'b1 && !st) begin
                n_chk++;
                if (pc_out !== exp_pc || inst !== f(exp_pc) || pc_next !== exp_pc + 32'd4)
                    $display("FAIL rnd_order k=%0d pc=%h inst=%h nx=%h exp pc %h",
                             k, pc_out, inst, pc_next, exp_pc);
                else n_pass++;
                exp_pc = exp_pc + 32'd4;
                ndel++;
            end
            pend = mem_req && !mem_ack;
            pend_pc = mem_pc;
            stall = st;
            redirect = rd;
            redirect_pc = rpc;
        end
        @(negedge clk);
        stall = 1'b0;
        redirect = 1'b0;
        n_chk++;
        if (ndel < 100)
            $display("FAIL rnd_progress delivered=%0d exp >=100", ndel);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency3();
        test_stall();
        test_redirect_discard();
        test_redirect_ack();
        test_second_redirect();
        test_wrap();
        test_reset_mid_request();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the address of the first fetch after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 stall  input  1  SHALL mean the decode stage is not accepting the presented instruction this cycle.
REQ-005 redirect  input  1  SHALL be a single-cycle pulse requesting a fetch restart at redirect_pc.
REQ-006 redirect_pc  input  32  SHALL be the branch/jump target, sampled only when redirect=1.
REQ-007 inst_valid  output  1  SHALL mean that inst/pc_out/pc_next carry a valid fetched instruction.
REQ-008 inst  output  32  SHALL be the instruction word at the FIFO head.
REQ-009 pc_out  output  32  SHALL be the PC of the FIFO head.
REQ-010 pc_next  output  32  SHALL be pc_out+4, modulo 2^32.
REQ-011 mem_req  output  1  SHALL be the instruction-memory request strobe.
REQ-012 mem_pc  output  32  SHALL be the instruction-memory request address.
REQ-013 mem_ack  input  1  SHALL be a one-cycle completion pulse; same-cycle acknowledgement (zero wait) is legal.
REQ-014 mem_inst  input  32  SHALL be the returned word, valid only while mem_ack=1.

Function
REQ-015 Storage SHALL be a 2-entry {pc, inst} FIFO plus registers fetch_pc, old_pc, and a state in {IDLE, REQ, DISCARD}.
REQ-016 Outputs SHALL be: inst_valid = (count!=0); inst and pc_out taken from the head entry.
REQ-017 The head SHALL pop at the clock edge when inst_valid=1 and stall=0.
REQ-018 mem_req SHALL be 1 only in REQ and DISCARD; mem_pc SHALL be fetch_pc in REQ, old_pc in DISCARD, and fetch_pc in IDLE.
REQ-019 Once mem_req=1, mem_pc SHALL stay constant until mem_ack.
REQ-020 IDLE -> REQ SHALL occur when the post-pop count is <2; otherwise the block stays in IDLE.
REQ-021 In REQ with mem_ack=1 and redirect=0, the block SHALL:
  - push {fetch_pc, mem_inst};
  - set fetch_pc += 4, wrapping at 2^32;
  - go to REQ if the resulting count is <2, else to IDLE.
REQ-022 A push and a pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-023 The FIFO SHALL never overflow; a push SHALL never be lost while count=1 and stall=1.
REQ-024 redirect=1 SHALL take priority over stall and over mem_ack; on redirect the block SHALL:
  - flush the FIFO, so count=0 and inst_valid=0 next cycle;
  - set fetch_pc = redirect_pc.
REQ-025 Redirect in REQ with mem_ack=0 SHALL set old_pc = the in-flight address and go to DISCARD.
REQ-026 Redirect in REQ with mem_ack=1 SHALL discard the returned word and stay in REQ.
REQ-027 Redirect in IDLE SHALL go to REQ.
REQ-028 DISCARD SHALL hold mem_req=1 with mem_pc=old_pc until mem_ack; the acknowledged word SHALL be dropped, then the block SHALL go to REQ.
REQ-029 Redirect while in DISCARD SHALL overwrite fetch_pc with the new redirect_pc and remain in DISCARD.
REQ-030 Delivered instructions SHALL be in strict program order, with no duplication and no skipping between redirects.
REQ-031 Throughput with zero-wait memory and stall=0 SHALL be one instruction per cycle.
REQ-032 Latency SHALL be: the instruction appears on inst the cycle after its mem_ack.

Reset
REQ-033 While rst=1 the block SHALL hold: state=IDLE, fetch_pc=RESET_PC, old_pc=0, count=0, FIFO entries=0.
REQ-034 During reset the outputs SHALL be: inst_valid=0, inst=0, pc_out=0, pc_next=4, mem_req=0.
REQ-035 Reset asserted mid-request SHALL abandon the outstanding request without waiting for mem_ack.
REQ-036 mem_req SHALL assert with mem_pc=RESET_PC in the first cycle after rst deasserts.

Verification
REQ-037 Zero-wait memory (ack every request), stall=0, reset released -> mem_pc = 0, 4, 8, ... one per cycle; pc_out follows one cycle later with inst_valid=1.
REQ-038 3-cycle memory latency -> mem_pc held stable for 3 cycles per request; each instruction is valid for exactly one cycle.
REQ-039 stall=1 for 5 cycles starting with PC 0x8 at the head -> count reaches 2 (0x8, 0xC), mem_req=0, and pc_out stays 0x8; after release, 0x8 then 0xC are delivered, then fetch resumes at 0x10.
REQ-040 Redirect to 0x100 while a request for 0x20 is pending without ack -> DISCARD holds mem_pc=0x20 until ack; that word is dropped; next mem_pc=0x100; 0x20 never appears on pc_out.
REQ-041 Redirect to 0x200 in the same cycle as mem_ack with stall=1 -> FIFO flushed, returned word dropped, next mem_pc=0x200.
REQ-042 Second redirect to 0x300 during DISCARD, and fetch_pc=0xFFFF_FFFC -> the first fetch after DISCARD is 0x300; in the wrap case, fetch after 0xFFFF_FFFC is 0x0000_0000 and pc_next=0.
